// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 iterative multiply/divide unit with integrated HI/LO registers.
// Optional MDU_DIVZERO_EXC_EN: divide by zero skips iteration, keeps HI/LO, pulses div_zero_o.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wd_i,
`ifdef MDU_DIVZERO_EXC_EN
  output logic             div_zero_o,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 div_q, div_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 divz_q, divz_d;

  logic                 sgn_a, sgn_b;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       shifted;
  logic                 ge;
  logic [WIDTH-1:0]     diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  assign sgn_a = ~op_i[0] & a_i[WIDTH-1];
  assign sgn_b = ~op_i[0] & b_i[WIDTH-1];
  assign a_mag = sgn_a ? -a_i : a_i;
  assign b_mag = sgn_b ? -b_i : b_i;

  // Multiply: accumulator upper half adds the multiplicand, whole thing shifts right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: upper half is the remainder, lower half shifts dividend out and quotient in.
  assign shifted  = acc_q[2*WIDTH-1:WIDTH-1];
  assign ge       = shifted >= {1'b0, m_q};
  assign diff     = shifted[WIDTH-1:0] - m_q;
  assign div_next = {(ge ? diff : shifted[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};

  assign prod = negq_q ? -acc_q : acc_q;
  assign quo  = dz_q ? '1 : (negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    m_d     = m_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    divz_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hi_we_i) hi_d = wd_i;
        if (lo_we_i) lo_d = wd_i;
        if (start_i) begin
          div_d   = op_i[1];
          negq_d  = sgn_a ^ sgn_b;
          negr_d  = sgn_a;
          dz_d    = (b_i == '0);
          m_d     = op_i[1] ? b_mag : a_mag;
          acc_d   = {{WIDTH{1'b0}}, (op_i[1] ? a_mag : b_mag)};
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_RUN;
`ifdef MDU_DIVZERO_EXC_EN
          if (op_i[1] && (b_i == '0)) state_d = S_FIX;
`endif
        end
      end
      S_RUN: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
`ifdef MDU_DIVZERO_EXC_EN
        if (div_q && dz_q) begin
          divz_d = 1'b1;
        end else if (div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          {hi_d, lo_d} = prod;
        end
`else
        if (div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          {hi_d, lo_d} = prod;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
`ifdef MDU_DIVZERO_EXC_EN
  assign div_zero_o = divz_q;
`else
  logic unused_divz;
  assign unused_divz = divz_q;
`endif

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed bench for mdu_iter (32-bit and 8-bit instances) with a result scoreboard.
module tb_mdu_iter;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, hi_we, lo_we;
  logic [1:0]    op;
  logic [W-1:0]  a, b, wd;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  logic          s_start, s_hi_we, s_lo_we;
  logic [1:0]    s_op;
  logic [7:0]    s_a, s_b, s_wd;
  logic          s_busy, s_done;
  logic [7:0]    s_hi, s_lo;

`ifdef MDU_DIVZERO_EXC_EN
  logic          div_zero, s_div_zero;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;
  res_t sb_q[$];

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32), .CNT_W(6)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .hi_we_i(hi_we), .lo_we_i(lo_we), .wd_i(wd),
`ifdef MDU_DIVZERO_EXC_EN
    .div_zero_o(div_zero),
`endif
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  mdu_iter #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .op_i(s_op), .a_i(s_a), .b_i(s_b),
    .hi_we_i(s_hi_we), .lo_we_i(s_lo_we), .wd_i(s_wd),
`ifdef MDU_DIVZERO_EXC_EN
    .div_zero_o(s_div_zero),
`endif
    .busy_o(s_busy), .done_o(s_done), .hi_o(s_hi), .lo_o(s_lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] eh, input logic [W-1:0] el);
    res_t e;
    e.hi = eh;
    e.lo = el;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done (bounded), counting busy cycles from the current negedge.
  task automatic wait_result(input string tag, input int exp_busy);
    int   n = 0;
    int   t = 0;
    res_t e;
    while (done !== 1'b1 && t < 200) begin
      if (busy === 1'b1) n++;
      t++;
      @(negedge clk);
    end
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    chk({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'(1));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
      chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
    end
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
  endtask

  task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] aa,
                      input logic [7:0] bb, input logic [7:0] eh, input logic [7:0] el);
    int n = 0;
    int t = 0;
    s_start = 1'b1;
    s_op    = o;
    s_a     = aa;
    s_b     = bb;
    @(negedge clk);
    s_start = 1'b0;
    while (s_done !== 1'b1 && t < 100) begin
      if (s_busy === 1'b1) n++;
      t++;
      @(negedge clk);
    end
    chk({tag, "_done"}, 64'(s_done), 64'(1));
    chk({tag, "_busy_cycles"}, 64'(n), 64'(9));
    chk({tag, "_hi"}, 64'(s_hi), 64'(eh));
    chk({tag, "_lo"}, 64'(s_lo), 64'(el));
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wd = '0;
    s_start = 1'b0; s_op = '0; s_a = '0; s_b = '0;
    s_hi_we = 1'b0; s_lo_we = 1'b0; s_wd = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    push(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0003);
    wait_result("mult_neg", 33);

    push(32'hFFFF_FFFE, 32'h0000_0001);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("multu_max", 33);

    // back-to-back issue in the done cycle
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    chk("b2b_done_single", 64'(done), 64'(0));
    chk("b2b_busy", 64'(busy), 64'(1));
    wait_result("div_b2b", 33);

    push(32'd2, 32'd14);
    issue(2'b11, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_result("divu_stray", 22);
    count_done(40, nd);
    chk("stray_no_extra_done", 64'(nd), 64'(0));
    chk("stray_hi_kept", 64'(hi), 64'(2));

    push(32'h0000_0000, 32'h8000_0000);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_ovf", 33);

    push(32'h0000_0001, 32'hFFFF_FFFD);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_result("div_pos_neg", 33);

`ifdef MDU_DIVZERO_EXC_EN
    push(32'h0000_0001, 32'hFFFF_FFFD);
    issue(2'b11, 32'd5, 32'd0);
    wait_result("divu_zero", 1);
    chk("divu_zero_flag", 64'(div_zero), 64'(1));
    @(negedge clk);
    chk("divu_zero_flag_pulse", 64'(div_zero), 64'(0));
    push(32'h0000_0001, 32'hFFFF_FFFD);
    issue(2'b10, 32'hFFFF_FFF7, 32'd0);
    wait_result("div_zero_signed", 1);
    chk("div_zero_signed_flag", 64'(div_zero), 64'(1));
`else
    push(32'd5, 32'hFFFF_FFFF);
    issue(2'b11, 32'd5, 32'd0);
    wait_result("divu_zero", 33);
    push(32'hFFFF_FFF7, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FFF7, 32'd0);
    wait_result("div_zero_signed", 33);
`endif

    @(negedge clk);
    hi_we = 1'b1; wd = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_idle", 64'(hi), 64'h1234_5678);
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_both", 64'(hi), 64'hCAFE_F00D);
    chk("mtlo_both", 64'(lo), 64'hCAFE_F00D);

    push(32'd0, 32'd6);
    issue(2'b01, 32'd2, 32'd3);
    hi_we = 1'b1; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_busy_ignored", 64'(hi), 64'hCAFE_F00D);
    wait_result("multu_small", 32);

    push(32'd0, 32'd25);
    lo_we = 1'b1; wd = 32'hAAAA_5555;
    issue(2'b01, 32'd5, 32'd5);
    lo_we = 1'b0;
    chk("mtlo_with_start", 64'(lo), 64'hAAAA_5555);
    wait_result("multu_after_mtlo", 33);

    @(negedge clk);
    hi_we = 1'b1; wd = 32'h55AA_55AA;
    @(negedge clk);
    hi_we = 1'b0;
    issue(2'b01, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hi", 64'(hi), 64'(0));
    chk("rst_mid_lo", 64'(lo), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    count_done(40, nd);
    chk("rst_mid_no_done", 64'(nd), 64'(0));
    chk("rst_mid_hi_after", 64'(hi), 64'(0));

    run8("w8_mult_min", 2'b00, 8'h80, 8'h80, 8'h40, 8'h00);
    run8("w8_div_ovf", 2'b10, 8'h80, 8'hFF, 8'h00, 8'h80);
    run8("w8_mult_mix", 2'b00, 8'h7F, 8'h80, 8'hC0, 8'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit with integrated HI/LO registers.
- Successor to the single-cycle combinational MDU plus separate HI/LO register blocks.
- Sits beside the ALU in EX. The pipeline issues an op with a one-cycle start pulse and stalls on busy.
- Radix-2 iterative engine: one bit per cycle, operand width parametrised.

Parameters:
WIDTH, 32, operand width and HI/LO width in bits (even, >= 4)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  issue op; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  operand A (multiplicand / dividend)
b  input  WIDTH  operand B (multiplier / divisor)
hi_we  input  1  direct HI write (MTHI)
lo_we  input  1  direct LO write (MTLO)
wd  input  WIDTH  direct write data
busy  output  1  op in flight; start ignored while high
done  output  1  one-cycle pulse when HI/LO receive a result
hi  output  WIDTH  HI register (product high / remainder)
lo  output  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset: all regs cleared asynchronously. hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0.
- FSM states:
  - IDLE: start=1 latches op, the operand magnitudes (|a|, |b| for signed ops; raw values for unsigned), and the sign flags. Counter loads WIDTH. Go to RUN; busy=1 from the next cycle.
  - RUN: one iteration per edge and the counter decrements. When the counter reaches 1, the final iteration executes and the FSM goes to FIX.
  - FIX: sign correction. HI/LO are written at this edge, done=1 for the following cycle, busy=0 in that same cycle, and the FSM returns to IDLE.
- Latency: start at edge E0 gives results on hi/lo after edge E0+WIDTH+1, with done high during that cycle. A new start is accepted in the done cycle (back-to-back issue).
- Multiply: shift-add over a 2*WIDTH accumulator.
  - MULT: the product is negated if sign(a) != sign(b). {hi,lo} = full 2*WIDTH signed product.
  - MULTU: unsigned product, no correction.
- Divide: restoring algorithm with a WIDTH+1 bit partial remainder.
  - DIV: quotient negated if the signs differ. Remainder takes the sign of the dividend.
  - DIVU: unsigned.
  - lo = quotient, hi = remainder.
- Overflow case: DIV of most-negative by -1 gives lo=most-negative, hi=0. This is wrap, with no flag.
- Divide by zero (macro absent): lo = all ones, hi = a (dividend unchanged). Full latency, done pulses normally.
- start while busy: ignored, no queueing. op/a/b are don't-care when start=0.
- Direct writes:
  - hi_we/lo_we take effect at the edge when busy=0. Both may assert together; both registers then get wd.
  - Ignored while busy=1, because the pipeline stalls MTHI/MTLO on busy.
  - Same edge as an accepted start: the direct write applies, and the op result later overwrites HI and LO.
- Reset asserted mid-operation: the op is aborted, all state clears immediately, and no done pulse is produced.
- hi/lo hold their value throughout RUN. They change only at the FIX edge or on a direct write.

Optional Feature:
MDU_DIVZERO_EXC_EN
- Defined: adds output port div_zero (1 bit, reset 0). When DIV/DIVU is started with b=0:
  - The FSM skips RUN and goes directly to FIX.
  - hi/lo are NOT modified.
  - done and div_zero pulse together for one cycle, 2 edges after start.
- Undefined: no div_zero port. Divide by zero follows the default rule above.

Test Plan:
- Reset, then MULT a=0xFFFFFFFF (-1), b=0x00000003 -> after 33 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFD; busy high for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then immediately issue DIV in the done cycle: a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=7 -> lo=14, hi=2. A second start pulsed mid-op is ignored: one done only, results unchanged.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5 (macro off); with the macro on, div_zero=1 and hi/lo retain their prior values.
- hi_we=1, wd=0x12345678 while idle -> hi=0x12345678. Same write attempted while busy -> hi unchanged until done. rst_n low mid-op -> hi=lo=0, busy=0, no done.
- WIDTH=8 instance: MULT a=0x80 (-128), b=0x80 -> hi=0x40, lo=0x00 after 9 edges.
